banked_sync_ram_ctrl: RTL and testbench
=======================================

Name: banked_sync_ram_ctrl

Overview:
Parametrised multi-bank single-port synchronous RAM with a valid/ready request port and a valid/ready response port.
- Generalises the fixed 4-bank, 2-half-word memory to 2^BANK_BITS banks of DATA_WIDTH words.
- Adds per-lane (byte) write enables.
- Uses separate write-data and read-data buses instead of a tristate bus.
- Sits between the CPU/ALU datapath and storage. Read data is registered and held until the consumer accepts it.

Parameters:
ADDR_WIDTH, 15, total word address width; the top BANK_BITS bits select the bank.
DATA_WIDTH, 16, word width; must be an integer multiple of LANE_WIDTH.
LANE_WIDTH, 8, write-enable granularity in bits.
BANK_BITS, 2, log2 of bank count; 1 <= BANK_BITS < ADDR_WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request this cycle.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  word address; [ADDR_WIDTH-1 -: BANK_BITS] = bank, remainder = word index.
req_wdata  input  DATA_WIDTH  write data.
req_lane_en  input  DATA_WIDTH/LANE_WIDTH  per-lane write enable; ignored on reads.
rsp_valid  output  1  read data valid.
rsp_ready  input  1  consumer accepts the read data.
rsp_rdata  output  DATA_WIDTH  registered read data.
rsp_bank  output  BANK_BITS  bank that produced rsp_rdata.

Behaviour:
- Storage: 2^BANK_BITS banks, each with DEPTH = 2^(ADDR_WIDTH-BANK_BITS) words. Only the addressed bank is touched per access.
- Handshake: a request is accepted on an edge where req_valid && req_ready. The response completes on an edge where rsp_valid && rsp_ready.
- FSM states: IDLE, RESP, plus CLEAR when RAM_CLEAR_EN is defined.
- req_ready = (state == IDLE) && !rst. Combinational from state only; never depends on req_valid.
- IDLE, write accepted:
  - Each lane i with req_lane_en[i] = 1 gets mem[bank][word][i*LANE_WIDTH +: LANE_WIDTH] = req_wdata lane i.
  - Lanes with enable 0 are unchanged. All-zero lane_en is accepted with no change.
  - No response is generated. State stays IDLE, so writes sustain one per cycle.
- IDLE, read accepted:
  - rsp_rdata <= mem[bank][word]; rsp_bank <= bank; rsp_valid <= 1; state -> RESP.
  - Latency: accept at edge N gives valid data from edge N (visible in cycle N+1).
- RESP:
  - rsp_rdata, rsp_bank and rsp_valid hold stable while rsp_ready = 0 (no limit on stall length).
  - On the rsp handshake edge: rsp_valid <= 0; state -> IDLE.
  - req_ready = 0 throughout RESP. Peak read throughput is one read per 2 cycles.
- Write-then-read of the same address on consecutive accepts returns the newly written data. There is no same-cycle hazard because there is one request per cycle.
- Reset (any state, including mid-RESP):
  - Next state is IDLE (or CLEAR with the macro). A pending response is discarded.
  - rsp_valid = 0, rsp_rdata = 0, rsp_bank = 0.
  - Memory contents are untouched by reset unless RAM_CLEAR_EN is defined.
- Address wrap: the address is fully decoded, so there is no out-of-range case. Each bank's word index spans 0..DEPTH-1 exactly.

Optional Feature:
RAM_CLEAR_EN
- Defined:
  - Reset leads to CLEAR. A word counter of width ADDR_WIDTH-BANK_BITS starts at 0.
  - Each cycle, word [counter] of every bank is written to 0, then the counter increments.
  - The cycle the counter writes DEPTH-1, the next state is IDLE. CLEAR lasts exactly DEPTH cycles; req_ready = 0 throughout.
  - Reset during CLEAR restarts the sweep at 0.
- Undefined: no CLEAR state, no counter. Reset leads to IDLE and unwritten words read back X.

Test Plan:
- Write 0xBEEF to addr 0x0005 with lane_en=2'b11, then read 0x0005 with rsp_ready=1 -> rsp_valid high one cycle after accept, rsp_rdata=0xBEEF, rsp_bank=0, req_ready low exactly one cycle.
- Write 0x1234 to 0x6005 (bank 3), then write 0xAB00 to 0x6005 with lane_en=2'b10, then read 0x6005 -> 0xAB34, rsp_bank=3. Addr 0x0005 still reads 0xBEEF (bank isolation).
- Read 0x6005 with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata=0xAB34 and rsp_bank=3 stable all 5 cycles, req_ready=0; rsp_ready=1 -> next cycle rsp_valid=0, req_ready=1.
- Back-to-back writes to 0x2000..0x2003 (values 1..4) on 4 consecutive cycles -> req_ready stays 1 throughout; reads return 1,2,3,4 with rsp_bank=1.
- Assert rst for 1 cycle while in RESP -> next cycle rsp_valid=0, rsp_rdata=0, rsp_bank=0; memory still holds 0xBEEF at 0x0005.
- RAM_CLEAR_EN with ADDR_WIDTH=6, BANK_BITS=2: write 0xFFFF to 0x3F, pulse rst -> req_ready low 16 cycles then high; read 0x3F -> 0x0000.

Source files
------------

// File: rtl/banked_sync_ram_ctrl_if.sv
// Request/response bus of banked_sync_ram_ctrl: valid/ready request port plus
// a registered valid/ready read-response port.
interface banked_sync_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int LANE_WIDTH = 8,
  parameter int BANK_BITS  = 2
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [LANES-1:0]      req_lane_en;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [BANK_BITS-1:0]  rsp_bank;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lane_en, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_bank
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lane_en, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_bank
  );
endinterface

// File: rtl/banked_sync_ram_ctrl.sv
// Multi-bank single-port synchronous RAM with lane write enables and a held read response.
// Optional macro RAM_CLEAR_EN: after reset, sweep every word of every bank to zero.
module banked_sync_ram_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int LANE_WIDTH = 8,
  parameter int BANK_BITS  = 2
) (
  input logic                   clk,
  input logic                   rst,
  banked_sync_ram_ctrl_if.slave bus
);
  localparam int LANES     = DATA_WIDTH / LANE_WIDTH;
  localparam int WORD_BITS = ADDR_WIDTH - BANK_BITS;
  localparam int NBANKS    = 1 << BANK_BITS;
  localparam int DEPTH     = 1 << WORD_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

`ifdef RAM_CLEAR_EN
  localparam state_t RST_STATE = ST_CLEAR;
  logic [WORD_BITS-1:0] r_clr_cnt;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_req_ready;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_rsp_fire;
  logic [BANK_BITS-1:0]  w_bank;
  logic [WORD_BITS-1:0]  w_word;
  logic [DATA_WIDTH-1:0] r_mem [NBANKS][DEPTH];
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [BANK_BITS-1:0]  r_rsp_bank;

  assign w_bank     = bus.req_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign w_word     = bus.req_addr[WORD_BITS-1:0];
  assign w_wr_fire  = bus.req_valid && w_req_ready && bus.req_we;
  assign w_rd_fire  = bus.req_valid && w_req_ready && !bus.req_we;
  assign w_rsp_fire = r_rsp_valid && bus.rsp_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_bank  = r_rsp_bank;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_fire) w_next_state = ST_RESP;
        else           w_next_state = ST_IDLE;
      end
      ST_RESP: begin
        if (w_rsp_fire) w_next_state = ST_IDLE;
        else            w_next_state = ST_RESP;
      end
`ifdef RAM_CLEAR_EN
      ST_CLEAR: begin
        if (r_clr_cnt == {WORD_BITS{1'b1}}) w_next_state = ST_IDLE;
        else                                w_next_state = ST_CLEAR;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: request acceptance depends on state (and reset) only
  always_comb begin
    w_req_ready = 1'b0;
    if ((r_state == ST_IDLE) && !rst) w_req_ready = 1'b1;
    else                              w_req_ready = 1'b0;
  end

`ifdef RAM_CLEAR_EN
  // Clear-sweep word counter, restarted by every reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt <= {WORD_BITS{1'b0}};
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + WORD_BITS'(1);
    end else begin
      r_clr_cnt <= r_clr_cnt;
    end
  end
`endif

  // Storage: per-lane writes to the addressed bank; no reset on the array itself
  always_ff @(posedge clk) begin
`ifdef RAM_CLEAR_EN
    if (!rst && (r_state == ST_CLEAR)) begin
      for (int b = 0; b < NBANKS; b++) begin
        r_mem[b][r_clr_cnt] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_wr_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.req_lane_en[l]) begin
          r_mem[w_bank][w_word][l*LANE_WIDTH +: LANE_WIDTH] <= bus.req_wdata[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
`else
    if (w_wr_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.req_lane_en[l]) begin
          r_mem[w_bank][w_word][l*LANE_WIDTH +: LANE_WIDTH] <= bus.req_wdata[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
`endif
  end

  // Read response registers: loaded on read accept, held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_WIDTH{1'b0}};
      r_rsp_bank  <= {BANK_BITS{1'b0}};
    end else if (w_rd_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= r_mem[w_bank][w_word];
      r_rsp_bank  <= w_bank;
    end else if (w_rsp_fire) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= r_rsp_rdata;
      r_rsp_bank  <= r_rsp_bank;
    end else begin
      r_rsp_valid <= r_rsp_valid;
      r_rsp_rdata <= r_rsp_rdata;
      r_rsp_bank  <= r_rsp_bank;
    end
  end
endmodule

// File: tb/tb_banked_sync_ram_ctrl.sv
// Directed self-checking bench for banked_sync_ram_ctrl (default parameters).
// Also exercises the RAM_CLEAR_EN sweep when that macro is defined.
module tb_banked_sync_ram_ctrl;
  localparam int DEPTH = 1 << 13;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  banked_sync_ram_ctrl_if #(.ADDR_WIDTH(15), .DATA_WIDTH(16), .LANE_WIDTH(8), .BANK_BITS(2)) bus ();

  banked_sync_ram_ctrl #(.ADDR_WIDTH(15), .DATA_WIDTH(16), .LANE_WIDTH(8), .BANK_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [14:0] a, input logic [15:0] d, input logic [1:0] le);
    bus.req_valid   = 1'b1;
    bus.req_we      = 1'b1;
    bus.req_addr    = a;
    bus.req_wdata   = d;
    bus.req_lane_en = le;
    tick();
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
  endtask

  task automatic do_read(input logic [14:0] a, output logic [15:0] d, output logic [1:0] b, output logic v);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
    v = bus.rsp_valid;
    d = bus.rsp_rdata;
    b = bus.rsp_bank;
    tick();
  endtask

`ifdef RAM_CLEAR_EN
  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (!bus.req_ready && n < bound) begin
      tick();
      n++;
    end
  endtask
`endif

  task automatic test_reset();
`ifdef RAM_CLEAR_EN
    int n;
`endif
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 15'h0;
    bus.req_wdata = 16'h0; bus.req_lane_en = 2'b00; bus.rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_bank} !== 19'h0) begin
      failures++; $display("FAIL reset_rsp: got v=%b d=%h b=%h expected all 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_bank);
    end
    rst = 1'b0;
`ifdef RAM_CLEAR_EN
    wait_ready(DEPTH + 8, n);
    checks++;
    if (n !== DEPTH) begin failures++; $display("FAIL reset_clear_len: got %0d expected %0d", n, DEPTH); end
`else
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready); end
`endif
  endtask

  task automatic test_write_read();
    do_write(15'h0005, 16'hBEEF, 2'b11);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 15'h0005;
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL wr_rd_ready_before: got %b expected 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_bank, bus.req_ready} !== {1'b1, 16'hBEEF, 2'd0, 1'b0}) begin
      failures++; $display("FAIL wr_rd_rsp: got v=%b d=%h b=%0d rdy=%b expected v=1 d=beef b=0 rdy=0",
                           bus.rsp_valid, bus.rsp_rdata, bus.rsp_bank, bus.req_ready);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      failures++; $display("FAIL wr_rd_after: got v=%b rdy=%b expected v=0 rdy=1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_lanes();
    logic [15:0] d; logic [1:0] b; logic v;
    do_write(15'h6005, 16'h1234, 2'b11);
    do_write(15'h6005, 16'hAB00, 2'b10);
    do_read(15'h6005, d, b, v);
    checks++;
    if ({v, d, b} !== {1'b1, 16'hAB34, 2'd3}) begin
      failures++; $display("FAIL lane_merge: got v=%b d=%h b=%0d expected v=1 d=ab34 b=3", v, d, b);
    end
    do_read(15'h0005, d, b, v);
    checks++;
    if ({v, d, b} !== {1'b1, 16'hBEEF, 2'd0}) begin
      failures++; $display("FAIL bank_isolation: got v=%b d=%h b=%0d expected v=1 d=beef b=0", v, d, b);
    end
  endtask

  task automatic test_stall();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 15'h6005;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_bank, bus.req_ready} !== {1'b1, 16'hAB34, 2'd3, 1'b0}) begin
        failures++; $display("FAIL stall_hold[%0d]: got v=%b d=%h b=%0d rdy=%b expected v=1 d=ab34 b=3 rdy=0",
                             i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_bank, bus.req_ready);
      end
      if (i < 4) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      failures++; $display("FAIL stall_release: got v=%b rdy=%b expected v=0 rdy=1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic [1:0] b; logic v;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.req_ready); end
      do_write(15'h2000 + 15'(i), 16'(i + 1), 2'b11);
    end
    do_write(15'h2000, 16'hFFFF, 2'b00);
    for (int i = 0; i < 4; i++) begin
      do_read(15'h2000 + 15'(i), d, b, v);
      checks++;
      if ({v, d, b} !== {1'b1, 16'(i + 1), 2'd1}) begin
        failures++; $display("FAIL b2b_read[%0d]: got v=%b d=%h b=%0d expected v=1 d=%h b=1", i, v, d, b, 16'(i + 1));
      end
    end
    do_write(15'h7FFF, 16'h5A5A, 2'b11);
    do_read(15'h7FFF, d, b, v);
    checks++;
    if ({v, d, b} !== {1'b1, 16'h5A5A, 2'd3}) begin
      failures++; $display("FAIL top_addr: got v=%b d=%h b=%0d expected v=1 d=5a5a b=3", v, d, b);
    end
  endtask

  task automatic test_reset_in_resp();
    logic [15:0] d; logic [1:0] b; logic v;
`ifdef RAM_CLEAR_EN
    int n;
    logic [15:0] exp_d = 16'h0000;
`else
    logic [15:0] exp_d = 16'hBEEF;
`endif
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 15'h6005;
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_bank, bus.req_ready} !== 20'h0) begin
      failures++; $display("FAIL rst_in_resp: got v=%b d=%h b=%0d rdy=%b expected all 0",
                           bus.rsp_valid, bus.rsp_rdata, bus.rsp_bank, bus.req_ready);
    end
    rst = 1'b0;
`ifdef RAM_CLEAR_EN
    wait_ready(DEPTH + 8, n);
    checks++;
    if (n !== DEPTH) begin failures++; $display("FAIL rst_in_resp_clear_len: got %0d expected %0d", n, DEPTH); end
`else
    #1;
`endif
    do_read(15'h0005, d, b, v);
    checks++;
    if ({v, d, b} !== {1'b1, exp_d, 2'd0}) begin
      failures++; $display("FAIL rst_mem_keep: got v=%b d=%h b=%0d expected v=1 d=%h b=0", v, d, b, exp_d);
    end
  endtask

`ifdef RAM_CLEAR_EN
  task automatic test_clear();
    logic [15:0] d; logic [1:0] b; logic v;
    int n;
    do_write(15'h7FFF, 16'hFFFF, 2'b11);
    do_read(15'h7FFF, d, b, v);
    checks++;
    if (d !== 16'hFFFF) begin failures++; $display("FAIL clear_pre: got %h expected ffff", d); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(DEPTH + 8, n);
    checks++;
    if (n !== DEPTH) begin failures++; $display("FAIL clear_len: got %0d expected %0d", n, DEPTH); end
    do_read(15'h7FFF, d, b, v);
    checks++;
    if ({v, d, b} !== {1'b1, 16'h0000, 2'd3}) begin
      failures++; $display("FAIL clear_data: got v=%b d=%h b=%0d expected v=1 d=0000 b=3", v, d, b);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_lanes();
    test_stall();
    test_back_to_back();
    test_reset_in_resp();
`ifdef RAM_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
